ball_mover: RTL

- Consumes the periodic `d_enable` tick from the frame-rate delay counter.
- On each accepted tick it:
  - erases the ball at its current position,
  - advances the ball one pixel per axis with wall, ceiling and paddle reflection,
  - redraws the ball at the new position.
- Pixel writes go to the downstream VGA plotter through a req/ack handshake.
- Also reports a ball-lost event to game control.

---
 rtl/ball_mover_if.sv | 13 +
 rtl/ball_mover.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ball_mover_if.sv
// Pixel-write channel from the ball mover to the VGA plotter.
// Handshake: plot_req high presents a pixel whose x/y/colour stay fixed until plot_ack is
// sampled high on a clock edge while plot_req is high; that edge completes the transfer.
interface ball_mover_if;
    logic       plot_req;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;
    logic       plot_ack;

    modport master (output plot_req, plot_x, plot_y, plot_colour, input plot_ack);
    modport slave  (input plot_req, plot_x, plot_y, plot_colour, output plot_ack);
endinterface

// File: rtl/ball_mover.sv
// Ball mover: per accepted frame tick, erase the ball, step it with wall/ceiling/paddle
// reflection (or respawn it on floor loss), then redraw it through the plotter handshake.
module ball_mover #(
    parameter logic [7:0] X_MAX       = 8'd159,
    parameter logic [6:0] Y_MAX       = 7'd119,
    parameter logic [7:0] X_INIT      = 8'd80,
    parameter logic [6:0] Y_INIT      = 7'd60,
    parameter logic [6:0] PADDLE_Y    = 7'd115,
    parameter logic [8:0] PADDLE_W    = 9'd16,
    parameter logic [2:0] BALL_COLOUR = 3'b111
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                tick,
    input  logic [7:0]          paddle_x,
    ball_mover_if.master        plot,
    output logic [7:0]          ball_x,
    output logic [6:0]          ball_y,
    output logic                ball_lost,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        UPDATE = 2'd2,
        DRAW   = 2'd3
    } state_t;

    state_t     state, state_n;
    logic       dx_neg, dy_neg, dx_neg_n, dy_neg_n;
    logic [7:0] ball_x_n;
    logic [6:0] ball_y_n;
    logic       on_paddle;
    logic       hit_floor;

    // Widened to 9 bits so a paddle near x=255 does not wrap around to cover x=0.
    assign on_paddle = ({1'b0, paddle_x} <= {1'b0, ball_x}) &&
                       ({1'b0, ball_x} <= ({1'b0, paddle_x} + PADDLE_W - 9'd1));
    assign hit_floor = !dy_neg && (ball_y == Y_MAX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            ball_x <= X_INIT;
            ball_y <= Y_INIT;
            dx_neg <= 1'b0;
            dy_neg <= 1'b1;
        end else begin
            state  <= state_n;
            ball_x <= ball_x_n;
            ball_y <= ball_y_n;
            dx_neg <= dx_neg_n;
            dy_neg <= dy_neg_n;
        end
    end

    always_comb begin
        state_n          = state;
        ball_x_n         = ball_x;
        ball_y_n         = ball_y;
        dx_neg_n         = dx_neg;
        dy_neg_n         = dy_neg;
        plot.plot_req    = 1'b0;
        plot.plot_x      = 8'd0;
        plot.plot_y      = 7'd0;
        plot.plot_colour = 3'd0;
        ball_lost        = 1'b0;

        case (state)
            IDLE: begin
                if (tick) state_n = ERASE;
            end
            ERASE: begin
                plot.plot_req = 1'b1;
                plot.plot_x   = ball_x;
                plot.plot_y   = ball_y;
                if (plot.plot_ack) state_n = UPDATE;
            end
            UPDATE: begin
                state_n = DRAW;
                if (!dx_neg && ball_x == X_MAX) begin
                    dx_neg_n = 1'b1;
                    ball_x_n = X_MAX - 8'd1;
                end else if (dx_neg && ball_x == 8'd0) begin
                    dx_neg_n = 1'b0;
                    ball_x_n = 8'd1;
                end else begin
                    ball_x_n = dx_neg ? ball_x - 8'd1 : ball_x + 8'd1;
                end

                if (dy_neg && ball_y == 7'd0) begin
                    dy_neg_n = 1'b0;
                    ball_y_n = 7'd1;
                end else if (!dy_neg && ball_y == PADDLE_Y - 7'd1 && on_paddle) begin
                    dy_neg_n = 1'b1;
                    ball_y_n = ball_y - 7'd1;
                end else begin
                    ball_y_n = dy_neg ? ball_y - 7'd1 : ball_y + 7'd1;
                end

                // Floor loss respawns the ball and overrides both axis results.
                if (hit_floor) begin
                    ball_lost = 1'b1;
                    ball_x_n  = X_INIT;
                    ball_y_n  = Y_INIT;
                    dx_neg_n  = 1'b0;
                    dy_neg_n  = 1'b1;
                end
            end
            DRAW: begin
                plot.plot_req    = 1'b1;
                plot.plot_x      = ball_x;
                plot.plot_y      = ball_y;
                plot.plot_colour = BALL_COLOUR;
                if (plot.plot_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
